// File: rtl/fp_mul_exc_pipe.sv
// Two-stage exception/special-result pipeline for the FP multiplier.
// Optional sticky status register enabled by defining FP_MUL_EXC_STICKY_EN.
module fp_mul_exc_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int SH_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     sx,
   input  logic                     sy,
   input  logic [EXP_W-1:0]         Ex,
   input  logic [EXP_W-1:0]         Ey,
   input  logic [EXP_W-1:0]         Ez,
   input  logic [MAN_W-1:0]         Mx,
   input  logic [MAN_W-1:0]         My,
   input  logic [MAN_W-1:0]         Mz,
   input  logic [SH_W-1:0]          required_shift,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     invalid_flag,
   output logic                     overflow_flag,
   output logic                     underflow_flag,
   output logic                     zero_flag,
   output logic [EXP_W-1:0]         exp_adj,
   output logic                     res_special,
   output logic [EXP_W+MAN_W:0]     res_bits,
   input  logic                     flags_clr,
   output logic [3:0]               sticky_flags
);

   logic v1, v2;
   logic s1_adv, s2_adv;

   assign s2_adv    = !v2 || out_ready;
   assign s1_adv    = !v1 || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = v2;

   // operand classification
   logic x_zero, x_inf, x_nan, y_zero, y_inf, y_nan, z_ovf;
   logic             borrow_c;
   logic [EXP_W-1:0] exp_adj_c;

   assign x_zero = (~|Ex) && (~|Mx);
   assign x_inf  = (&Ex)  && (~|Mx);
   assign x_nan  = (&Ex)  && (|Mx);
   assign y_zero = (~|Ey) && (~|My);
   assign y_inf  = (&Ey)  && (~|My);
   assign y_nan  = (&Ey)  && (|My);
   assign z_ovf  = (&Ez)  && (~|Mz);
   assign {borrow_c, exp_adj_c} = {1'b0, Ez} - {{(EXP_W+1-SH_W){1'b0}}, required_shift};

   logic             xz_q, xi_q, xn_q, yz_q, yi_q, yn_q, zovf_q, sign_q, borrow_q;
   logic [EXP_W-1:0] exp_adj1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1         <= 1'b0;
         xz_q       <= 1'b0;
         xi_q       <= 1'b0;
         xn_q       <= 1'b0;
         yz_q       <= 1'b0;
         yi_q       <= 1'b0;
         yn_q       <= 1'b0;
         zovf_q     <= 1'b0;
         sign_q     <= 1'b0;
         borrow_q   <= 1'b0;
         exp_adj1_q <= '0;
      end else if (s1_adv) begin
         v1 <= in_valid;
         if (in_valid) begin
            xz_q       <= x_zero;
            xi_q       <= x_inf;
            xn_q       <= x_nan;
            yz_q       <= y_zero;
            yi_q       <= y_inf;
            yn_q       <= y_nan;
            zovf_q     <= z_ovf;
            sign_q     <= sx ^ sy;
            borrow_q   <= borrow_c;
            exp_adj1_q <= exp_adj_c;
         end
      end
   end

   // prioritised flags: invalid > overflow > zero > underflow
   logic                 inv_c, ovf_c, zero_c, unf_c;
   logic [EXP_W+MAN_W:0] res_bits_c;

   always_comb begin
      inv_c      = (xz_q && yi_q) || (xi_q && yz_q) || xn_q || yn_q;
      ovf_c      = !inv_c && (xi_q || yi_q || zovf_q);
      zero_c     = !inv_c && !ovf_c && (xz_q || yz_q);
      unf_c      = borrow_q && !inv_c && !ovf_c && !zero_c;
      res_bits_c = '0;
      if (inv_c)
         res_bits_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (ovf_c)
         res_bits_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (zero_c)
         res_bits_c = {sign_q, {(EXP_W+MAN_W){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v2             <= 1'b0;
         invalid_flag   <= 1'b0;
         overflow_flag  <= 1'b0;
         underflow_flag <= 1'b0;
         zero_flag      <= 1'b0;
         exp_adj        <= '0;
         res_special    <= 1'b0;
         res_bits       <= '0;
      end else if (s2_adv) begin
         v2 <= v1;
         if (v1) begin
            invalid_flag   <= inv_c;
            overflow_flag  <= ovf_c;
            underflow_flag <= unf_c;
            zero_flag      <= zero_c;
            exp_adj        <= exp_adj1_q;
            res_special    <= inv_c || ovf_c || zero_c;
            res_bits       <= res_bits_c;
         end
      end
   end

`ifdef FP_MUL_EXC_STICKY_EN
   logic       xfer;
   logic [3:0] cur_flags;

   assign xfer      = out_valid && out_ready;
   assign cur_flags = {invalid_flag, overflow_flag, underflow_flag, zero_flag};

   // a transfer coinciding with a clear leaves only the new event
   always_ff @(posedge clk) begin
      if (rst)
         sticky_flags <= 4'b0;
      else if (xfer && flags_clr)
         sticky_flags <= cur_flags;
      else if (xfer)
         sticky_flags <= sticky_flags | cur_flags;
      else if (flags_clr)
         sticky_flags <= 4'b0;
   end
`else
   logic flags_clr_unused;
   assign flags_clr_unused = flags_clr;
   assign sticky_flags     = 4'b0;
`endif

endmodule

// File: tb/tb_fp_mul_exc_pipe.sv
// Randomized scoreboard bench for fp_mul_exc_pipe plus directed corner cases.
// Sticky checks follow FP_MUL_EXC_STICKY_EN when defined for the build.
module tb_fp_mul_exc_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, sx, sy, out_valid, out_ready, flags_clr;
   logic [7:0]  Ex, Ey, Ez, exp_adj;
   logic [22:0] Mx, My, Mz;
   logic [4:0]  required_shift;
   logic        invalid_flag, overflow_flag, underflow_flag, zero_flag, res_special;
   logic [31:0] res_bits;
   logic [3:0]  sticky_flags;

   fp_mul_exc_pipe #(.EXP_W(8), .MAN_W(23), .SH_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sx(sx), .sy(sy), .Ex(Ex), .Ey(Ey), .Ez(Ez), .Mx(Mx), .My(My), .Mz(Mz),
      .required_shift(required_shift), .out_valid(out_valid), .out_ready(out_ready),
      .invalid_flag(invalid_flag), .overflow_flag(overflow_flag),
      .underflow_flag(underflow_flag), .zero_flag(zero_flag), .exp_adj(exp_adj),
      .res_special(res_special), .res_bits(res_bits), .flags_clr(flags_clr),
      .sticky_flags(sticky_flags)
   );

   typedef logic [44:0] res_t;
   res_t out_bus;
   assign out_bus = {invalid_flag, overflow_flag, underflow_flag, zero_flag,
                     exp_adj, res_special, res_bits};

   int   total = 0;
   int   bad   = 0;
   res_t q[$];
   logic [3:0] sticky_m = 4'b0;
   bit   hold_pending = 0;
   res_t held;
   bit   last_acc, last_xfer, saw_stall;
   res_t last_bus;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // reference built straight from the classification and priority rules
   function automatic res_t model(input logic s_x, s_y, input logic [7:0] ex, ey, ez,
                                  input logic [22:0] mx, my, mz, input logic [4:0] sh);
      bit xz = (ex == 0) && (mx == 0);
      bit xi = (ex == 8'hFF) && (mx == 0);
      bit xn = (ex == 8'hFF) && (mx != 0);
      bit yz = (ey == 0) && (my == 0);
      bit yi = (ey == 8'hFF) && (my == 0);
      bit yn = (ey == 8'hFF) && (my != 0);
      bit inv = (xz && yi) || (xi && yz) || xn || yn;
      bit ovf = !inv && (xi || yi || (ez == 8'hFF && mz == 0));
      bit zer = !inv && !ovf && (xz || yz);
      int d = int'(ez) - int'(sh);
      bit unf = (d < 0) && !inv && !ovf && !zer;
      logic s = s_x ^ s_y;
      logic [7:0] ea = d[7:0];
      logic [31:0] rb = inv ? 32'h7FC00000 : ovf ? {s, 8'hFF, 23'h0} : zer ? {s, 31'h0} : 32'h0;
      return {inv, ovf, unf, zer, ea, inv | ovf | zer, rb};
   endfunction

   task automatic set_in(input logic a, b, input logic [7:0] ex, ey, ez,
                         input logic [22:0] mx, my, mz, input logic [4:0] sh);
      sx = a; sy = b; Ex = ex; Ey = ey; Ez = ez; Mx = mx; My = my; Mz = mz;
      required_shift = sh;
   endtask

   function automatic logic [7:0] rexp();
      case ($urandom % 4)
         0: return 8'h00;
         1: return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic logic [22:0] rman();
      return ($urandom % 3 == 0) ? 23'h0 : 23'($urandom);
   endfunction

   task automatic rand_in();
      logic [7:0] ez;
      case ($urandom % 3)
         0: ez = 8'hFF;
         1: ez = 8'($urandom % 32);
         default: ez = 8'($urandom);
      endcase
      set_in(1'($urandom), 1'($urandom), rexp(), rexp(), ez, rman(), rman(),
             ($urandom % 2) ? 23'h0 : 23'($urandom), 5'($urandom));
   endtask

   // one clock: sample/score at negedge, then advance past the posedge
   task automatic step();
      res_t e;
      @(negedge clk);
      check("sticky", sticky_flags, sticky_m);
      if (hold_pending) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", out_bus, held);
      end
      check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (!in_ready) saw_stall = 1;
      last_acc  = in_valid && in_ready;
      last_xfer = out_valid && out_ready;
      last_bus  = out_bus;
      if (last_xfer) begin
         if (q.size() == 0) check("spurious_out", 1, 0);
         else begin
            e = q.pop_front();
            check("data", out_bus, e);
`ifdef FP_MUL_EXC_STICKY_EN
            sticky_m = flags_clr ? e[44:41] : (sticky_m | e[44:41]);
`endif
         end
      end else if (flags_clr) sticky_m = 4'b0;
      if (last_acc) q.push_back(model(sx, sy, Ex, Ey, Ez, Mx, My, Mz, required_shift));
      hold_pending = out_valid && !out_ready;
      held = out_bus;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1; in_valid = 0; flags_clr = 0;
      @(posedge clk); #1;
      rst = 0;
      q.delete(); sticky_m = 4'b0; hold_pending = 0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", out_bus, 0);
      check("rst_sticky", sticky_flags, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
   endtask

   // push one bundle, then wait for its transfer and check the 2-edge latency
   task automatic send_one(input string tag);
      int n;
      in_valid = 1; out_ready = 1;
      step();
      check({tag, "_accept"}, last_acc, 1);
      in_valid = 0;
      n = 0;
      do begin step(); n++; end while (!last_xfer && n < 8);
      check({tag, "_latency"}, n, 2);
   endtask

   initial begin
      int sent, got;
      rst = 1; in_valid = 0; out_ready = 1; flags_clr = 0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      set_in(0, 1, 8'h7F, 8'hFF, 8'h7F, 0, 0, 0, 0);
      send_one("one_x_inf");
      check("one_x_inf_flags", last_bus[44:41], 4'b0100);
      check("one_x_inf_special", last_bus[32], 1);
      check("one_x_inf_bits", last_bus[31:0], 32'hFF800000);

      set_in(0, 0, 8'h00, 8'hFF, 8'h7F, 0, 0, 0, 0);
      send_one("zero_x_inf");
      check("zero_x_inf_flags", last_bus[44:41], 4'b1000);
      check("zero_x_inf_bits", last_bus[31:0], 32'h7FC00000);

      set_in(0, 0, 8'h7F, 8'h7F, 8'h03, 0, 0, 0, 5'd5);
      send_one("borrow");
      check("borrow_flags", last_bus[44:41], 4'b0010);
      check("borrow_exp_adj", last_bus[40:33], 8'hFE);

      set_in(0, 0, 8'h7F, 8'h7F, 8'h05, 0, 0, 0, 5'd5);
      send_one("no_borrow");
      check("no_borrow_flags", last_bus[44:41], 4'b0000);
      check("no_borrow_exp_adj", last_bus[40:33], 8'h00);

      // sticky accumulate, then clear coinciding with an overflow transfer
      do_reset();
      set_in(0, 0, 8'h00, 8'h7F, 8'h40, 0, 0, 0, 0);
      send_one("stk_zero");
      set_in(0, 0, 8'hFF, 8'h7F, 8'h40, 23'h1, 0, 0, 0);
      send_one("stk_inv");
`ifdef FP_MUL_EXC_STICKY_EN
      check("sticky_accum", sticky_flags, 4'b1001);
`else
      check("sticky_off", sticky_flags, 4'b0000);
`endif
      flags_clr = 1;
      set_in(1, 0, 8'hFF, 8'h7F, 8'h40, 0, 0, 0, 0);
      send_one("stk_ovf_clr");
      flags_clr = 0;
`ifdef FP_MUL_EXC_STICKY_EN
      check("sticky_clr_ovf", sticky_flags, 4'b0100);
`else
      check("sticky_off2", sticky_flags, 4'b0000);
`endif

      // backpressure: 4 bundles back-to-back, out_ready low for 3 cycles
      sent = 0; got = 0; saw_stall = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         in_valid  = (sent < 4);
         out_ready = !(c >= 2 && c < 5);
         set_in(sent[0], 1'b0, 8'h70 + 8'(sent), 8'h7F, 8'h10, 23'(sent), 0, 0, 5'(sent * 7));
         step();
         if (last_acc) sent++;
         if (last_xfer) got++;
      end
      in_valid = 0; out_ready = 1;
      check("bp_stall_seen", saw_stall, 1);
      check("bp_delivered", got, 4);
      check("bp_queue_empty", q.size(), 0);

      // reset with two bundles held in flight
      out_ready = 0; in_valid = 1;
      rand_in(); step();
      rand_in(); step();
      in_valid = 0;
      check("mid_inflight", q.size(), 2);
      do_reset();
      out_ready = 1;
      for (int i = 0; i < 5; i++) step();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 10) < 7;
         flags_clr = ($urandom % 10) == 0;
         rand_in();
         step();
      end
      in_valid = 0; out_ready = 1; flags_clr = 0;
      for (int i = 0; i < 10 && q.size() > 0; i++) step();
      check("drain_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fp_mul_exc_pipe.md
# fp_mul_exc_pipe

Parametrised, pipelined exception and special-result unit for the FPU floating-point multiplier. Classifies both operands and the raw product exponent, produces mutually prioritised invalid/overflow/underflow/zero flags plus a substitute special result. Two register stages with valid/ready backpressure, plus an optional sticky status register for the FPU status word. Sits between the multiplier's normalise stage and the rounding/writeback stage.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, mantissa field width (≥2)
- SH_W, 5, width of required_shift (SH_W ≤ EXP_W)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/product bundle valid
- in_ready  out  1  block can accept bundle this cycle
- sx, sy  in  1 each  operand signs
- Ex, Ey, Ez  in  EXP_W each  operand and raw product exponents
- Mx, My, Mz  in  MAN_W each  operand and raw product mantissas (fraction only)
- required_shift  in  SH_W  normalisation left-shift amount for product
- out_valid  out  1  result bundle valid
- out_ready  in  1  downstream accepts bundle
- invalid_flag, overflow_flag, underflow_flag, zero_flag  out  1 each  per-operation flags
- exp_adj  out  EXP_W  Ez − required_shift, low EXP_W bits
- res_special  out  1  downstream must substitute res_bits
- res_bits  out  1+EXP_W+MAN_W  {sign, exp, man} special result
- flags_clr  in  1  clear sticky flags
- sticky_flags  out  4  {invalid, overflow, underflow, zero} accumulated

## Operation
- Classification, per operand: zero = exp all-0 & man all-0; inf = exp all-1 & man all-0; NaN = exp all-1 & man ≠ 0. Denormals (exp 0, man ≠ 0) are finite non-zero.
- invalid = (x zero & y inf) | (x inf & y zero) | x NaN | y NaN.
- overflow = !invalid & ((x inf | y inf) | (Ez all-1 & Mz all-0)).
- zero = !invalid & !overflow & (x zero | y zero).
- {borrow, exp_adj} = {1'b0,Ez} − zero-extended required_shift, EXP_W+1 bits; underflow = borrow & !invalid & !overflow & !zero.
- At most one flag set per operation. Priority invalid > overflow > zero > underflow.
- res_sign = sx ^ sy. res_special = invalid|overflow|zero. res_bits: invalid → {0, all-1, 1 followed by MAN_W−1 zeros} (canonical qNaN); overflow → {res_sign, all-1, 0}; zero → {res_sign, 0, 0}; otherwise all zero.
- Stage 1 registers operand classification, res_sign, borrow/exp_adj, Ez/Mz special bits. Stage 2 registers flags, res_special, res_bits, exp_adj.

## Timing
- Latency 2 cycles: bundle accepted at edge N (in_valid & in_ready) appears with out_valid at edge N+2 when unstalled. Throughput 1/cycle.
- Stage k advances when stage k empty or stage k+1 advances; stage 2 advances when !out_valid | out_ready. in_ready = stage 1 advances (combinational from out_ready; no skid buffer).
- While out_valid & !out_ready, all outputs hold stable.
- Reset: out_valid=0, all flags 0, exp_adj=0, res_special=0, res_bits=0, sticky_flags=0, stage valids 0. Reset mid-operation discards all in-flight bundles; in_ready=1 on first cycle after reset deasserts.
- Sticky update on output transfer (out_valid & out_ready): sticky |= flags. flags_clr alone zeroes sticky next edge; flags_clr with transfer in same cycle → sticky = that transfer's flags (new event wins).

## Configuration
- FP_MUL_EXC_STICKY_EN defined: sticky register and flags_clr as above.
- Not defined: no sticky register; sticky_flags tied to 4'b0, flags_clr ignored; ports remain present.

## Test plan
- 1.0×inf: Ex=8'h7F,Mx=0,Ey=8'hFF,My=0,sx=0,sy=1 → after 2 cycles overflow=1 only, res_bits=32'hFF800000, res_special=1.
- 0×inf: Ex=0,Mx=0,Ey=8'hFF,My=0 → invalid=1, overflow=0, zero=0, res_bits=32'h7FC00000.
- Underflow/borrow: Ez=8'h03, required_shift=5'd5, finite non-zero operands → underflow=1, exp_adj=8'hFE; Ez=8'h05, shift 5 → underflow=0, exp_adj=0.
- Backpressure: stream 4 bundles back-to-back, hold out_ready=0 for 3 cycles mid-stream → in_ready drops once both stages full, outputs stable, all 4 delivered in order, none lost or duplicated.
- Sticky (macro on): op with zero then op with invalid → sticky=4'b1001; assert flags_clr in same cycle as an overflow transfer → sticky=4'b0100; without macro sticky stays 0.
- Reset mid-stream: assert rst with 2 bundles in flight → next cycle out_valid=0, all outputs 0, no stale bundle emerges afterwards.
